des_cbc_feeder: RTL and testbench
=================================

Name: des_cbc_feeder

Overview:
- Sequential front-end for the combinational DES encrypt core (core ports: message, key, iv → ciphertext; the core XORs iv internally).
- Accepts 64-bit plaintext blocks over a valid/ready stream and drives message/key/iv to the core, holding them stable for a fixed settle time.
- Captures the ciphertext, returns it over a valid/ready stream, and chains it as the next block's IV (CBC).
- Replaces the bench-level chaining loop with synthesizable control.

Parameters:
- WAIT_CYC, 1, clocks core inputs are held stable before core_ct is sampled; legal range 1..15.
- CNT_W, 18, width of the block counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; begins a new message; honoured only in IDLE.
- key_in  in  64  DES key; sampled on accepted start.
- iv_init  in  64  initial IV; sampled on accepted start.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  feeder can accept a block.
- in_block  in  64  plaintext block; bit 64 is DES bit 1.
- in_last  in  1  marks the final block of the message; qualified by in_valid.
- core_msg  out  64  to core message.
- core_key  out  64  to core key.
- core_iv  out  64  to core iv.
- core_ct  in  64  from core ciphertext.
- out_valid  out  1  ciphertext block valid.
- out_ready  in  1  downstream accepts.
- out_block  out  64  ciphertext block.
- out_last  out  1  final block flag; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last block handshakes out.
- blk_count  out  CNT_W  blocks encrypted since the last start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state←IDLE.
  - All outputs, including core_*, out_block and blk_count, go to 0.
  - Internal key, IV, message and last registers clear to 0.
  - Reset applies in any state; a block in flight is discarded and no done pulse is issued.
- States: IDLE, ACCEPT, RUN, OUT.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 → key_reg←key_in, iv_reg←iv_init, blk_count←0, go to ACCEPT.
- ACCEPT:
  - in_ready=1, combinational from state.
  - On in_valid&in_ready: msg_reg←in_block, last_reg←in_last, wait_cnt←WAIT_CYC-1, go to RUN.
  - Otherwise stay in ACCEPT indefinitely.
- RUN:
  - core_msg=msg_reg, core_key=key_reg, core_iv=iv_reg, all registered and constant for the whole state.
  - If wait_cnt≠0: decrement.
  - If wait_cnt=0: out_block←core_ct, iv_reg←core_ct, out_last←last_reg, blk_count←blk_count+1, go to OUT.
- OUT:
  - out_valid=1; out_block and out_last stay stable until the handshake.
  - On out_valid&out_ready:
    - If last_reg: go to IDLE, done=1 in the following cycle only.
    - Else: go to ACCEPT.
- core_* outputs keep their last values outside RUN. They are don't-care to the core there, but must not glitch to X.
- start is ignored when state≠IDLE; there is no mid-message restart except via reset.
- start and a stale in_valid in IDLE: only start acts; no block is taken.
- Timing: input handshake to out_valid is WAIT_CYC+1 clocks. Minimum block period is WAIT_CYC+2 clocks with in_valid and out_ready held high.
- blk_count wraps from 2^CNT_W-1 to 0 with no other effect.
- A message of one block (in_last=1 on the first block) is legal.

Test Plan:
- Reset, single block: reset 3 clk; key_in=133457799BBCDFF1, iv_init=0, in_block=0123456789ABCDEF, in_last=1, core = DES encrypt core → out_block=85E813540F0AB405, out_last=1, blk_count=1, done pulses once, then IDLE with busy=0.
- Chaining: same key, iv_init=0, two blocks 0123456789ABCDEF then 0123456789ABCDEF (last) → core_iv during block 2 RUN = 85E813540F0AB405; out_block 2 matches the bench CBC model.
- Backpressure: hold out_ready=0 for 10 clk in OUT → out_valid stays 1, out_block unchanged, in_ready=0, blk_count unchanged; release → proceeds.
- Latency: WAIT_CYC=4, in_valid and out_ready held 1 → out_valid rises 5 clk after the input handshake; block period is 6 clk; core inputs constant across RUN.
- Reset mid-RUN: assert rst_n=0 during RUN of block 3 → next cycle all outputs 0, IDLE, no done; a new start with iv_init=0 reproduces the first-block result 85E813540F0AB405.
- Ignored start and wrap: pulse start during OUT → no effect on iv_reg or blk_count. With CNT_W=2, 5 blocks → blk_count reads 1 at the end.

Source files
------------

// File: rtl/des_cbc_feeder.sv
// CBC front-end for a combinational DES encrypt core: takes plaintext blocks,
// holds the core inputs for WAIT_CYC clocks, returns ciphertext and chains it as the next IV.
module des_cbc_feeder #(
  parameter int WAIT_CYC = 1,   // legal 1..15
  parameter int CNT_W    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      key_in,
  input  logic [63:0]      iv_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_block,
  input  logic             in_last,
  output logic [63:0]      core_msg,
  output logic [63:0]      core_key,
  output logic [63:0]      core_iv,
  input  logic [63:0]      core_ct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_block,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_RUN, S_OUT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

  state_t           state_q, state_d;
  logic [63:0]      key_q, key_d;
  logic [63:0]      iv_q, iv_d;
  logic [63:0]      msg_q, msg_d;
  logic [63:0]      ckey_q, ckey_d;
  logic [63:0]      civ_q, civ_d;
  logic [63:0]      oblk_q, oblk_d;
  logic             last_q, last_d;
  logic             olast_q, olast_d;
  logic             done_q, done_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic start_fire, in_fire, run_end, out_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)          state_d = S_ACCEPT;
      S_ACCEPT: if (in_valid)       state_d = S_RUN;
      S_RUN:    if (wcnt_q == 4'd0) state_d = S_OUT;
      S_OUT:    if (out_ready)      state_d = last_q ? S_IDLE : S_ACCEPT;
      default:                      state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (state_q == S_ACCEPT);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
  end

  assign start_fire = (state_q == S_IDLE) && start;
  assign in_fire    = in_ready && in_valid;
  assign run_end    = (state_q == S_RUN) && (wcnt_q == 4'd0);
  assign out_fire   = out_valid && out_ready;

  // Core inputs are snapshotted on accept so they stay frozen through RUN and
  // beyond, even though iv_q moves to the new ciphertext at the end of RUN.
  always_comb begin
    key_d   = key_q;
    iv_d    = iv_q;
    msg_d   = msg_q;
    ckey_d  = ckey_q;
    civ_d   = civ_q;
    oblk_d  = oblk_q;
    last_d  = last_q;
    olast_d = olast_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (start_fire) begin
      key_d = key_in;
      iv_d  = iv_init;
      cnt_d = '0;
    end

    if (in_fire) begin
      msg_d  = in_block;
      ckey_d = key_q;
      civ_d  = iv_q;
      last_d = in_last;
      wcnt_d = WAIT_LOAD;
    end

    if (state_q == S_RUN) begin
      if (run_end) begin
        oblk_d  = core_ct;
        iv_d    = core_ct;
        olast_d = last_q;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
    end

    if (out_fire && last_q) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= '0;
      iv_q    <= '0;
      msg_q   <= '0;
      ckey_q  <= '0;
      civ_q   <= '0;
      oblk_q  <= '0;
      last_q  <= 1'b0;
      olast_q <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      key_q   <= key_d;
      iv_q    <= iv_d;
      msg_q   <= msg_d;
      ckey_q  <= ckey_d;
      civ_q   <= civ_d;
      oblk_q  <= oblk_d;
      last_q  <= last_d;
      olast_q <= olast_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_msg  = msg_q;
  assign core_key  = ckey_q;
  assign core_iv   = civ_q;
  assign out_block = oblk_q;
  assign out_last  = olast_q;
  assign done      = done_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_des_cbc_feeder.sv
// Directed bench for des_cbc_feeder with a behavioural DES core (ct = DES(msg ^ iv, key)).
module tb_des_cbc_feeder;

  localparam int WC = 4;
  localparam int CW = 2;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] des_enc(input logic [63:0] pt, input logic [63:0] key);
    logic [63:0] ipv, pre, res;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k, e;
    logic [31:0] l, r, so, f, t;
    logic [5:0]  six;
    int          v;
    for (int i = 0; i < 64; i++) ipv[63-i] = pt[64-IP_T[i]];
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28]; d = cd[27:0]; l = ipv[63:32]; r = ipv[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SH_T[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ k;
      for (int b = 0; b < 8; b++) begin
        six = e[47-6*b -: 6];
        v = SB[b][int'({six[5], six[0]})*16 + int'(six[4:1])];
        so[31-4*b -: 4] = 4'(v);
      end
      for (int i = 0; i < 32; i++) f[31-i] = so[32-P_T[i]];
      t = l ^ f; l = r; r = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0]   key_in = '0, iv_init = '0, in_block = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [63:0]   core_msg, core_key, core_iv, core_ct, out_block;
  logic [CW-1:0] blk_count;
  int            n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign core_ct = des_enc(core_msg ^ core_iv, core_key);

  des_cbc_feeder #(.WAIT_CYC(WC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .iv_init(iv_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_last(in_last),
    .core_msg(core_msg), .core_key(core_key), .core_iv(core_iv), .core_ct(core_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_last(out_last),
    .busy(busy), .done(done), .blk_count(blk_count));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [63:0] k, input logic [63:0] iv);
    start = 1'b1; key_in = k; iv_init = iv;
    tick;
    start = 1'b0; key_in = '0; iv_init = '0;
  endtask

  // Offers one block, then returns in the first cycle out_valid is high.
  // lat counts clocks from the handshake cycle; stable flags any core input change during RUN.
  task automatic send_block(input logic [63:0] blk, input logic last, output int lat,
                            output logic [63:0] run_iv, output logic stable);
    logic [63:0] m, k;
    int guard = 0;
    while (!in_ready && guard < 20) begin tick; guard++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d clk, want 1", in_ready, guard);
    end
    in_valid = 1'b1; in_block = blk; in_last = last;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    lat = 1; run_iv = core_iv; m = core_msg; k = core_key; stable = 1'b1;
    while (!out_valid && lat < 40) begin
      if (core_msg !== m || core_key !== k || core_iv !== run_iv) stable = 1'b0;
      tick; lat++;
    end
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d clk, want 1", out_valid, lat);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    n_chk++; if ({busy, in_ready, out_valid, done, out_last} !== 5'b0) begin n_fail++;
      $display("FAIL rst_ctrl: busy/in_ready/out_valid/done/out_last=%b want 00000",
               {busy, in_ready, out_valid, done, out_last}); end
    n_chk++; if ({core_msg, core_key, core_iv, out_block} !== 256'b0 || blk_count !== '0) begin n_fail++;
      $display("FAIL rst_data: msg=%h key=%h iv=%h ob=%h cnt=%0d want all 0",
               core_msg, core_key, core_iv, out_block, blk_count); end
    rst_n = 1'b1;
    tick;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy=%b want 0", busy); end
  endtask

  task automatic test_single;
    int lat; logic [63:0] riv; logic stab;
    do_start(KEY, 64'h0);
    n_chk++; if ({in_ready, busy} !== 2'b11) begin n_fail++;
      $display("FAIL single_accept: in_ready/busy=%b want 11", {in_ready, busy}); end
    send_block(PT, 1'b1, lat, riv, stab);
    n_chk++; if (out_block !== K1) begin n_fail++; $display("FAIL single_ct: got %h want %h", out_block, K1); end
    n_chk++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", out_last); end
    n_chk++; if (blk_count !== 2'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", blk_count); end
    n_chk++; if (lat !== WC + 1) begin n_fail++; $display("FAIL single_lat: got %0d want %0d", lat, WC + 1); end
    tick;
    n_chk++; if ({done, busy} !== 2'b10) begin n_fail++;
      $display("FAIL single_done: done/busy=%b want 10", {done, busy}); end
    tick;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_chain;
    int lat; logic [63:0] riv, exp; logic stab;
    do_start(KEY, 64'h0);
    send_block(PT, 1'b0, lat, riv, stab);
    n_chk++; if ({out_block, out_last} !== {K1, 1'b0}) begin n_fail++;
      $display("FAIL chain_b1: got %h/%b want %h/0", out_block, out_last, K1); end
    tick;
    send_block(PT, 1'b1, lat, riv, stab);
    exp = des_enc(PT ^ K1, KEY);
    n_chk++; if (riv !== K1) begin n_fail++; $display("FAIL chain_core_iv: got %h want %h", riv, K1); end
    n_chk++; if (stab !== 1'b1) begin n_fail++; $display("FAIL chain_run_stable: got %b want 1", stab); end
    n_chk++; if (out_block !== exp) begin n_fail++; $display("FAIL chain_b2: got %h want %h", out_block, exp); end
    n_chk++; if (blk_count !== 2'd2) begin n_fail++; $display("FAIL chain_cnt: got %0d want 2", blk_count); end
    tick; tick;
  endtask

  task automatic test_back_to_back;
    int t[3]; int n = 0; int cy = 0;
    do_start(KEY, 64'h0);
    in_valid = 1'b1; in_block = PT; in_last = 1'b0;
    while (cy < 60 && !done) begin
      if (out_valid && n < 3) begin
        t[n] = cy; n++;
        if (n == 2) in_last = 1'b1;
      end
      tick; cy++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_chk++; if (done !== 1'b1 || n !== 3) begin n_fail++;
      $display("FAIL b2b_blocks: done=%b outs=%0d want 1/3", done, n); end
    else begin
      n_chk++; if (t[0] !== WC + 1) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", t[0], WC + 1); end
      n_chk++; if (t[1] - t[0] !== WC + 2 || t[2] - t[1] !== WC + 2) begin n_fail++;
        $display("FAIL b2b_period: got %0d,%0d want %0d", t[1] - t[0], t[2] - t[1], WC + 2); end
    end
    n_chk++; if (blk_count !== 2'd3) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 3", blk_count); end
    tick;
  endtask

  task automatic test_backpressure;
    int lat; int bad = 0; logic [63:0] riv, ob; logic stab;
    do_start(KEY, 64'h0);
    out_ready = 1'b0;
    send_block(PT, 1'b0, lat, riv, stab);
    ob = out_block;
    repeat (10) begin
      tick;
      if (out_valid !== 1'b1 || out_block !== ob || in_ready !== 1'b0 ||
          blk_count !== 2'd1 || out_last !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0 || ob !== K1) begin n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, ob=%h want 0 and %h", bad, ob, K1); end
    out_ready = 1'b1;
    tick;
    n_chk++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++;
      $display("FAIL bp_release: in_ready/out_valid=%b want 10", {in_ready, out_valid}); end
    send_block(PT, 1'b1, lat, riv, stab);
    n_chk++; if (out_block !== des_enc(PT ^ K1, KEY)) begin n_fail++;
      $display("FAIL bp_b2: got %h want %h", out_block, des_enc(PT ^ K1, KEY)); end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    int lat; int dn = 0; logic [63:0] riv; logic stab;
    do_start(KEY, 64'h0);
    send_block(PT, 1'b0, lat, riv, stab); tick;
    send_block(PT, 1'b0, lat, riv, stab); tick;
    in_valid = 1'b1; in_block = PT; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    n_chk++; if ({busy, in_ready, out_valid, done, out_last} !== 5'b0 || blk_count !== '0) begin n_fail++;
      $display("FAIL midrst_ctrl: ctrl=%b cnt=%0d want 00000/0",
               {busy, in_ready, out_valid, done, out_last}, blk_count); end
    n_chk++; if ({core_msg, core_key, core_iv, out_block} !== 256'b0) begin n_fail++;
      $display("FAIL midrst_data: msg=%h key=%h iv=%h ob=%h want all 0",
               core_msg, core_key, core_iv, out_block); end
    rst_n = 1'b1;
    repeat (8) begin tick; if (done) dn++; end
    n_chk++; if (dn !== 0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL midrst_nodone: done pulses=%0d busy=%b want 0/0", dn, busy); end
    do_start(KEY, 64'h0);
    send_block(PT, 1'b1, lat, riv, stab);
    n_chk++; if (out_block !== K1) begin n_fail++; $display("FAIL midrst_restart: got %h want %h", out_block, K1); end
    tick; tick;
  endtask

  task automatic test_ignored_start_wrap;
    int lat; int bad = 0; logic [63:0] riv, exp, exp_iv; logic stab;
    in_valid = 1'b1; in_block = 64'hFFFF_FFFF_FFFF_FFFF;
    do_start(KEY, 64'h0);
    in_valid = 1'b0;
    n_chk++; if ({in_ready, blk_count} !== {1'b1, 2'd0}) begin n_fail++;
      $display("FAIL stale_valid: in_ready=%b cnt=%0d want 1/0", in_ready, blk_count); end
    exp_iv = 64'h0;
    for (int b = 0; b < 5; b++) begin
      send_block(PT, (b == 4), lat, riv, stab);
      exp = des_enc(PT ^ exp_iv, KEY);
      if (out_block !== exp || riv !== exp_iv) bad++;
      exp_iv = exp;
      if (b == 0) begin
        start = 1'b1; key_in = 64'hDEAD_BEEF_0000_1111; iv_init = 64'h1111_2222_3333_4444;
        tick;
        start = 1'b0; key_in = '0; iv_init = '0;
        n_chk++; if ({in_ready, blk_count} !== {1'b1, 2'd1}) begin n_fail++;
          $display("FAIL ign_start: in_ready=%b cnt=%0d want 1/1", in_ready, blk_count); end
      end else begin
        tick;
      end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL ign_chain: %0d bad blocks want 0", bad); end
    n_chk++; if (core_key !== KEY) begin n_fail++; $display("FAIL ign_key: got %h want %h", core_key, KEY); end
    n_chk++; if ({blk_count, done} !== {2'd1, 1'b1}) begin n_fail++;
      $display("FAIL wrap_cnt: cnt=%0d done=%b want 1/1", blk_count, done); end
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_chain;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_ignored_start_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
